nonce_uart_tx: RTL
==================

// Module: nonce_uart_tx
// PURPOSE
//   UART transmitter for the miner's result path. Runs in the opposite direction to the
//   block-header receive path: it returns the winning nonce to the host.
//   On a send request it latches the 32-bit nonce and emits one 6-byte result packet on
//   txd as 8N1 serial frames:
//     sync 0xA5, nonce[31:24], nonce[23:16], nonce[15:8], nonce[7:0], checksum.
//   Sits in the 100 MHz clock domain between the processor's timeToSend/nonce outputs and
//   the board txd pin.
// PARAMETERS
//   CLKS_PER_BIT  868   clock cycles per serial bit (100 MHz / 115200 baud); legal >= 2
//   SYNC_BYTE     8'hA5 first byte of every packet
// PORTS
//   clock  in   1   system clock; all logic on posedge
//   reset  in   1   synchronous, active-high reset
//   send   in   1   request; sampled only while busy==0
//   nonce  in   32  nonce to report; captured on the cycle send is accepted
//   txd    out  1   serial output; idle/stop level 1, start bit 0
//   busy   out  1   high from the cycle after acceptance until the packet completes
//   done   out  1   one-cycle pulse when the final stop bit of the checksum byte ends
// BEHAVIOUR
//   Reset values
//     txd=1, busy=0, done=0; FSM in IDLE; all counters and shadow registers cleared.
//   Reset mid-packet
//     Aborts the transfer. Outputs return to reset values on the next edge.
//     The partially sent packet is not resumed.
//   Acceptance
//     In IDLE, send=1 latches nonce into a 32-bit shadow register, computes
//     checksum = nonce[31:24]^nonce[23:16]^nonce[15:8]^nonce[7:0] (sync byte excluded),
//     and sets byte index 0. On the next edge busy=1 and txd=0 (start bit of the sync byte).
//   Ignored inputs
//     send while busy=1 is ignored. Changes to nonce after acceptance have no effect.
//   FSM
//     IDLE  -> START  on accept.
//     START -> DATA   after CLKS_PER_BIT cycles.
//     DATA  -> STOP   after 8 bits. Bits are sent LSB first, each held CLKS_PER_BIT cycles.
//     STOP  -> START  after CLKS_PER_BIT cycles at txd=1, if byte index < 5; increment index.
//     STOP  -> IDLE   if byte index == 5. On that edge busy=0 and done=1 for exactly one cycle.
//   Timing
//     No inter-byte idle gap. Each byte is 10 bit-times; the packet is 60*CLKS_PER_BIT
//     cycles from the first txd fall to done.
//   Counters
//     Bit-timer counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
//     Bit counter is 0..7. Byte index is 0..5 (3 bits); values 6-7 are unreachable.
//   Back-to-back
//     In the done cycle busy=0, so send=1 in that cycle is accepted. The next packet's
//     start bit appears on the following edge, giving zero idle bit-times between packets.
//   Simultaneous reset and send: reset wins; nothing is latched.
//   Byte mux
//     index 0 = SYNC_BYTE, 1-4 = shadow bytes MSB first, 5 = checksum.
//   txd is driven from a register (glitch-free, no combinational path from inputs).
// TESTING  (CLKS_PER_BIT=4 for simulation)
//   1. Reset idle: hold reset 3 cycles, then idle 50 cycles
//      -> txd=1, busy=0, done=0 throughout.
//   2. send=1 for 1 cycle with nonce=32'h42A14695
//      -> receiver model decodes A5 42 A1 46 95 30; done pulses exactly 240 cycles after
//         txd first falls; busy high for the whole interval.
//   3. Mid-packet change: during case 2, at cycle 100 drive nonce=32'hFFFFFFFF and send=1
//      -> packet bytes are unchanged; no second packet follows.
//   4. Back-to-back: assert send=1 with nonce=32'h00000001 in the done cycle of case 2
//      -> next start bit on the following edge; decodes A5 00 00 00 01 01.
//   5. Reset mid-frame: assert reset at cycle 57 of a packet
//      -> next edge txd=1, busy=0, done never pulses; a new send afterwards produces a
//         complete, correct packet.
//   6. nonce=32'h00000000
//      -> decodes A5 00 00 00 00 00; data bits are all 0 with the stop bits correctly high.

Source files
------------

// File: rtl/nonce_uart_tx.sv
// 8N1 UART transmitter for the winning nonce: sends sync, four nonce bytes (MSB first) and
// an XOR checksum as one back-to-back 6-byte packet, with all outputs driven from registers.
module nonce_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        send,
  input  logic [31:0] nonce,
  output logic        txd,
  output logic        busy,
  output logic        done
);

  localparam int unsigned TIMER_W = $clog2(CLKS_PER_BIT);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LAST_BYTE = 3'd5;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state, state_n;
  logic [TIMER_W-1:0] bit_timer, bit_timer_n;
  logic [2:0]         bit_cnt, bit_cnt_n;
  logic [2:0]         byte_idx, byte_idx_n;
  logic [31:0]        shadow, shadow_n;
  logic [7:0]         checksum, checksum_n;
  logic               txd_n, busy_n, done_n;
  logic [7:0]         cur_byte;
  logic [2:0]         bit_next;
  logic               bit_end;

  // Packet byte selected by the current byte index
  always_comb begin
    cur_byte = SYNC_BYTE;
    case (byte_idx)
      3'd0:    cur_byte = SYNC_BYTE;
      3'd1:    cur_byte = shadow[31:24];
      3'd2:    cur_byte = shadow[23:16];
      3'd3:    cur_byte = shadow[15:8];
      3'd4:    cur_byte = shadow[7:0];
      3'd5:    cur_byte = checksum;
      default: cur_byte = SYNC_BYTE;
    endcase
  end

  assign bit_end  = (bit_timer == TIMER_LAST);
  assign bit_next = bit_cnt + 3'd1;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      bit_timer <= '0;
      bit_cnt   <= '0;
      byte_idx  <= '0;
      shadow    <= '0;
      checksum  <= '0;
      txd       <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      bit_timer <= bit_timer_n;
      bit_cnt   <= bit_cnt_n;
      byte_idx  <= byte_idx_n;
      shadow    <= shadow_n;
      checksum  <= checksum_n;
      txd       <= txd_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

  // Next state and next registered outputs; the txd level for the upcoming bit is
  // computed here so the pin changes exactly on the bit boundary edge.
  always_comb begin
    state_n     = state;
    bit_timer_n = bit_end ? '0 : bit_timer + TIMER_W'(1);
    bit_cnt_n   = bit_cnt;
    byte_idx_n  = byte_idx;
    shadow_n    = shadow;
    checksum_n  = checksum;
    txd_n       = txd;
    busy_n      = busy;
    done_n      = 1'b0;

    case (state)
      IDLE: begin
        bit_timer_n = '0;
        txd_n       = 1'b1;
        if (send) begin
          shadow_n   = nonce;
          checksum_n = nonce[31:24] ^ nonce[23:16] ^ nonce[15:8] ^ nonce[7:0];
          byte_idx_n = '0;
          bit_cnt_n  = '0;
          state_n    = START;
          txd_n      = 1'b0;
          busy_n     = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_n   = DATA;
          bit_cnt_n = '0;
          txd_n     = cur_byte[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt == 3'd7) begin
            state_n = STOP;
            txd_n   = 1'b1;
          end else begin
            bit_cnt_n = bit_next;
            txd_n     = cur_byte[bit_next];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (byte_idx == LAST_BYTE) begin
            state_n = IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            byte_idx_n = byte_idx + 3'd1;
            state_n    = START;
            txd_n      = 1'b0;
          end
        end
      end
      default: begin
        state_n = IDLE;
        txd_n   = 1'b1;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule
